// File: rtl/calc_arb_pkg.sv
// Shared constants and types for the calc-unit arbiter.
// Optional feature macro: CALC_ARB_LOCK_EN (grant lock), see calc_unit_arbiter.sv.
package calc_arb_pkg;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_OP_WIDTH     = 816;  // {kernel 25x16, window 25x16, bias 16}
  localparam int DEF_RES_WIDTH    = 16;
  localparam int DEF_CALC_LATENCY = 7;

  // Tag index sized for the largest supported requester count (8).
  localparam int IDX_MAX_W = 3;

  // Index width for n requesters, never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Owner tag carried alongside each in-flight operation.
  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/calc_unit_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester above the pointer, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;

  // Scan ptr+1, ptr+2, ... ptr+N (mod N); the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (i_en && !w_found && i_req[(int'(i_ptr) + i) % N]) begin
        o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
        o_idx   = IW'((int'(i_ptr) + i) % N);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_unit_arbiter.sv
// Round-robin arbiter sharing one fixed-latency MAC unit between N_REQ
// layer controllers, with an owner-tag pipeline routing results back.
// Optional: define CALC_ARB_LOCK_EN to let a granted requester with lock_i
// high keep top priority; otherwise lock_i is ignored.
module calc_unit_arbiter
  import calc_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int OP_WIDTH     = DEF_OP_WIDTH,
  parameter int RES_WIDTH    = DEF_RES_WIDTH,
  parameter int CALC_LATENCY = DEF_CALC_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [N_REQ*OP_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [OP_WIDTH-1:0]       calc_data_o,
  output logic                      calc_valid_o,
  input  logic [RES_WIDTH-1:0]      calc_result_i,
  output logic [N_REQ-1:0]          res_valid_o,
  output logic [RES_WIDTH-1:0]      res_data_o,
  output logic                      busy_o
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0]        r_ptr;
  logic [OP_WIDTH-1:0]  r_calc_data;
  logic                 r_calc_valid;
  logic [N_REQ-1:0]     r_res_valid;
  logic [RES_WIDTH-1:0] r_res_data;
  // Stage 0 is loaded with calc_valid_o; stages 1..CALC_LATENCY cover the
  // calc unit latency, so the last stage lines up with a valid calc_result_i.
  tag_t                 r_tag [0:CALC_LATENCY];

  logic [N_REQ-1:0]     w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_xfer;
  logic                 w_en;
  logic [IW-1:0]        w_ptr_nxt;
  logic                 w_tag_any;

  // Grants are suppressed combinationally during reset as well as when disabled.
  assign w_en = arb_en_i & rst_n;

  rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_xfer = |w_gnt;
  assign gnt_o  = w_gnt;

`ifdef CALC_ARB_LOCK_EN
  // A locked winner parks the pointer just below itself so it is searched first.
  always_comb begin
    w_ptr_nxt = w_idx;
    if (lock_i[w_idx])
      w_ptr_nxt = (w_idx == '0) ? IW'(N_REQ - 1) : w_idx - 1'b1;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock_i;
  assign w_ptr_nxt     = w_idx;
`endif

  // Pointer and operand register: capture the winner's bundle at the transfer edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= IW'(N_REQ - 1);
      r_calc_data  <= '0;
      r_calc_valid <= 1'b0;
    end else begin
      r_calc_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr       <= w_ptr_nxt;
        r_calc_data <= req_data_i[int'(w_idx)*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Owner tag pipeline: advances every cycle, never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= CALC_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0].valid <= w_xfer;
      r_tag[0].idx   <= IDX_MAX_W'(w_idx);
      for (int i = 1; i <= CALC_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Result return: strobe the owner and latch the calc unit output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= '0;
      r_res_data  <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++)
        r_res_valid[k] <= r_tag[CALC_LATENCY].valid &&
                          (r_tag[CALC_LATENCY].idx == IDX_MAX_W'(k));
      if (r_tag[CALC_LATENCY].valid) r_res_data <= calc_result_i;
    end
  end

  // Any tag stage holding a live operation.
  always_comb begin
    w_tag_any = 1'b0;
    for (int i = 0; i <= CALC_LATENCY; i++) w_tag_any = w_tag_any | r_tag[i].valid;
  end

  assign calc_data_o  = r_calc_data;
  assign calc_valid_o = r_calc_valid;
  assign res_valid_o  = r_res_valid;
  assign res_data_o   = r_res_data;
  assign busy_o       = r_calc_valid | w_tag_any | (|r_res_valid);

endmodule
